// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants for the IF0 next-PC generator.
// The misaligned() helper is the single definition of an ADEF address.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h1c00_0000;
  localparam int unsigned STEP_BYTES_DEFAULT = 8;

  typedef logic [31:0] pc_t;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    ADEF_HOLD = 2'd2
  } pcgen_state_t;

  // Instructions are word aligned, so any nonzero low bit is an address error.
  function automatic logic misaligned(input pc_t pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// IF0 -> IF1/IF2 boundary: redirect/stall requests in, fetch PC pair out.
// master = PC generator, slave = the pipeline side that consumes the pair.
interface pc_fetch_gen_if;
  import fetch_pkg::*;

  logic flush_EX;
  pc_t  i_EX_target;
  logic flush_BR;
  pc_t  i_BR_target;
  logic stall_ICache;

  pc_t  o_PC1;
  pc_t  o_PC2;
  logic o_PC2_valid;
  logic o_bubble;
  logic o_adef;

  modport master (
    input  flush_EX, i_EX_target, flush_BR, i_BR_target, stall_ICache,
    output o_PC1, o_PC2, o_PC2_valid, o_bubble, o_adef
  );

  modport slave (
    output flush_EX, i_EX_target, flush_BR, i_BR_target, stall_ICache,
    input  o_PC1, o_PC2, o_PC2_valid, o_bubble, o_adef
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux with alignment check and FSM next-state.
// Priority in RUN: exception redirect, branch redirect, stall hold, sequential.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned STEP_BYTES = STEP_BYTES_DEFAULT
) (
  input  pcgen_state_t state_i,
  input  logic         flush_ex_i,
  input  pc_t          ex_target_i,
  input  logic         flush_br_i,
  input  pc_t          br_target_i,
  input  logic         stall_i,
  input  pc_t          pc1_i,
  output pc_t          next_pc_o,
  output logic         next_bubble_o,
  output logic         set_adef_o,
  output logic         clr_adef_o,
  output pcgen_state_t next_state_o
);

  logic ex_mis;
  logic br_mis;
  pc_t  seq_pc;

  assign ex_mis = misaligned(ex_target_i);
  assign br_mis = misaligned(br_target_i);
  // A pair starting at bit2=1 only has one usable slot, so step 4 to realign.
  assign seq_pc = pc1_i[2] ? (pc1_i + 32'd4) : (pc1_i + 32'(STEP_BYTES));

  always_comb begin
    next_state_o = state_i;
    case (state_i)
      BOOT: next_state_o = RUN;
      RUN: begin
        if (flush_ex_i)      next_state_o = ex_mis ? ADEF_HOLD : RUN;
        else if (flush_br_i) next_state_o = br_mis ? ADEF_HOLD : RUN;
      end
      ADEF_HOLD: begin
        if (flush_ex_i && !ex_mis) next_state_o = RUN;
      end
      default: next_state_o = BOOT;
    endcase
  end

  always_comb begin
    next_pc_o     = pc1_i;
    next_bubble_o = 1'b0;
    set_adef_o    = 1'b0;
    clr_adef_o    = 1'b0;
    case (state_i)
      BOOT: begin
        next_pc_o     = pc1_i;
        next_bubble_o = 1'b0;
      end
      RUN: begin
        if (flush_ex_i) begin
          next_pc_o     = ex_target_i;
          next_bubble_o = ex_mis;
          set_adef_o    = ex_mis;
          clr_adef_o    = !ex_mis;
        end else if (flush_br_i) begin
          next_pc_o     = br_target_i;
          next_bubble_o = br_mis;
          set_adef_o    = br_mis;
        end else if (!stall_i) begin
          next_pc_o = seq_pc;
        end
      end
      ADEF_HOLD: begin
        next_bubble_o = 1'b1;
        if (flush_ex_i) begin
          next_pc_o     = ex_target_i;
          next_bubble_o = ex_mis;
          set_adef_o    = ex_mis;
          clr_adef_o    = !ex_mis;
        end
      end
      default: next_bubble_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// IF0 next-PC generator: holds the FSM state and the registered fetch pair.
// All selection logic lives in pc_next_sel; this level is flops only.
module pc_fetch_gen
  import fetch_pkg::*;
#(
  parameter pc_t         RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned STEP_BYTES = STEP_BYTES_DEFAULT
) (
  input  logic               clk,
  input  logic               rstn,
  pc_fetch_gen_if.master     fetch
);

  pcgen_state_t state_q, state_d;
  pc_t          pc1_q, pc2_q, pc1_d;
  logic         pc2_valid_q, bubble_q, adef_q;
  logic         bubble_d, adef_d;
  logic         set_adef, clr_adef;

  pc_next_sel #(
    .STEP_BYTES (STEP_BYTES)
  ) u_next_sel (
    .state_i       (state_q),
    .flush_ex_i    (fetch.flush_EX),
    .ex_target_i   (fetch.i_EX_target),
    .flush_br_i    (fetch.flush_BR),
    .br_target_i   (fetch.i_BR_target),
    .stall_i       (fetch.stall_ICache),
    .pc1_i         (pc1_q),
    .next_pc_o     (pc1_d),
    .next_bubble_o (bubble_d),
    .set_adef_o    (set_adef),
    .clr_adef_o    (clr_adef),
    .next_state_o  (state_d)
  );

  // Clear takes precedence: an aligned exception redirect always drops ADEF.
  assign adef_d = clr_adef ? 1'b0 : (set_adef ? 1'b1 : adef_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc1_q       <= RESET_PC;
      pc2_q       <= RESET_PC + 32'd4;
      pc2_valid_q <= 1'b0;
      bubble_q    <= 1'b1;
      adef_q      <= 1'b0;
    end else begin
      pc1_q       <= pc1_d;
      pc2_q       <= pc1_d + 32'd4;
      pc2_valid_q <= ~pc1_d[2] & ~bubble_d;
      bubble_q    <= bubble_d;
      adef_q      <= adef_d;
    end
  end

  assign fetch.o_PC1       = pc1_q;
  assign fetch.o_PC2       = pc2_q;
  assign fetch.o_PC2_valid = pc2_valid_q;
  assign fetch.o_bubble    = bubble_q;
  assign fetch.o_adef      = adef_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed, table-driven bench for pc_fetch_gen plus async-reset sequences.
module tb_pc_fetch_gen;
  import fetch_pkg::*;

  typedef struct packed {
    logic fex;
    pc_t  ext;
    logic fbr;
    pc_t  brt;
    logic stall;
    pc_t  pc;
    logic bub;
    logic v;
    logic adef;
  } vec_t;

  localparam int NVEC = 25;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NVEC];

  pc_fetch_gen_if intf ();

  pc_fetch_gen dut (
    .clk   (clk),
    .rstn  (rstn),
    .fetch (intf.master)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic fex, pc_t ext, logic fbr, pc_t brt, logic stall,
                              pc_t pc, logic bub, logic v, logic adef);
    vec_t r;
    r = '{fex, ext, fbr, brt, stall, pc, bub, v, adef};
    return r;
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic check_all(int idx, pc_t pc, logic bub, logic v, logic adef);
    check("pc1", idx, intf.o_PC1, pc);
    check("pc2", idx, intf.o_PC2, pc + 32'd4);
    check("pc2_valid", idx, 32'(intf.o_PC2_valid), 32'(v));
    check("bubble", idx, 32'(intf.o_bubble), 32'(bub));
    check("adef", idx, 32'(intf.o_adef), 32'(adef));
    $display("vec %0d: pc1=%h pc2=%h v=%0b bub=%0b adef=%0b", idx, intf.o_PC1,
             intf.o_PC2, intf.o_PC2_valid, intf.o_bubble, intf.o_adef);
  endtask

  task automatic drive(logic fex, pc_t ext, logic fbr, pc_t brt, logic stall);
    intf.flush_EX     = fex;
    intf.i_EX_target  = ext;
    intf.flush_BR     = fbr;
    intf.i_BR_target  = brt;
    intf.stall_ICache = stall;
  endtask

  initial begin
    //            fex  ex_tgt        fbr  br_tgt        stl  exp_pc1       bub  v     adef
    vecs[0]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000000, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000008, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000010, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h1c000010, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 32'h0,        1'b1, 32'h1c000200, 1'b1, 32'h1c000200, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h1c000200, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000208, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 32'h0,        1'b1, 32'h1c000104, 1'b0, 32'h1c000104, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000108, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 32'h1c000800, 1'b1, 32'h1c000300, 1'b0, 32'h1c000800, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000808, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 32'h0,        1'b1, 32'hfffffff8, 1'b0, 32'hfffffff8, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000008, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 32'h0,        1'b1, 32'h1c000102, 1'b0, 32'h1c000102, 1'b1, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 32'h0,        1'b1, 32'h1c000400, 1'b0, 32'h1c000102, 1'b1, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h1c000102, 1'b1, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000102, 1'b1, 1'b0, 1'b1);
    vecs[18] = mk(1'b1, 32'h1c000101, 1'b0, 32'h0,        1'b0, 32'h1c000101, 1'b1, 1'b0, 1'b1);
    vecs[19] = mk(1'b1, 32'h1c008000, 1'b0, 32'h0,        1'b0, 32'h1c008000, 1'b0, 1'b1, 1'b0);
    vecs[20] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c008008, 1'b0, 1'b1, 1'b0);
    vecs[21] = mk(1'b1, 32'h1c000003, 1'b0, 32'h0,        1'b0, 32'h1c000003, 1'b1, 1'b0, 1'b1);
    vecs[22] = mk(1'b1, 32'h1c000004, 1'b0, 32'h0,        1'b0, 32'h1c000004, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1c000008, 1'b0, 1'b1, 1'b0);
    vecs[24] = mk(1'b1, 32'h1c000006, 1'b0, 32'h0,        1'b0, 32'h1c000006, 1'b1, 1'b0, 1'b1);

    rstn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #12;
    check_all(100, 32'h1c000000, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].fex, vecs[i].ext, vecs[i].fbr, vecs[i].brt, vecs[i].stall);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].pc, vecs[i].bub, vecs[i].v, vecs[i].adef);
    end

    // Asynchronous reset between clock edges while stalled in ADEF_HOLD.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_all(200, 32'h1c000000, 1'b1, 1'b0, 1'b0);

    // A redirect pending during reset must not survive into the restart.
    drive(1'b0, 32'h0, 1'b1, 32'h1c000900, 1'b0);
    @(posedge clk);
    #1;
    check_all(201, 32'h1c000000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_all(202, 32'h1c000000, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_all(203, 32'h1c000008, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
